// File: rtl/mem_responder_if.sv
// mem_responder_if
// Memory-port bundle between the CPU controller (master) and the memory
// responder (slave).
//   memRead / memWrite : request strobes from the controller
//   adr / wdata        : word address and write data from the controller
//   rdata              : registered read data back to the controller
//   ready              : one-cycle completion pulse
//   err                : sticky illegal-request flag
//   rd_count/wr_count  : completed read/write counters (zero unless built in)
interface mem_responder_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              memRead;
    logic              memWrite;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              err;
    logic [15:0]       rd_count;
    logic [15:0]       wr_count;

    modport master (
        output memRead, memWrite, adr, wdata,
        input  rdata, ready, err, rd_count, wr_count
    );

    modport slave (
        input  memRead, memWrite, adr, wdata,
        output rdata, ready, err, rd_count, wr_count
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the accumulator CPU memory port. Accepts a single
// read or write request in IDLE, waits WAIT_STATES cycles, performs the access
// on the edge into RESP and pulses ready for that one RESP cycle.
// Ports:
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset (RAM contents are kept)
//   bus  : mem_responder_if.slave (memRead, memWrite, adr, wdata in;
//          rdata, ready, err, rd_count, wr_count out)
// Optional feature: define MEM_RESP_PERF_EN to build saturating 16-bit
// completed-read/write counters; otherwise both counters read 0.
module mem_responder #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    // For WAIT_STATES = 0 the load value is never used (IDLE goes straight
    // to RESP), so the wrap to 4'hF is harmless.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              op_rd_reg;
    logic [ADDR_W-1:0] adr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;

    logic              accept;
    logic              err_set;
    logic              enter_resp;
    logic              acc_rd;
    logic [ADDR_W-1:0] acc_adr;
    logic [DATA_W-1:0] acc_wdata;

    logic [DATA_W-1:0] ram [2**ADDR_W];

    // With zero wait states the access happens on the accept edge itself,
    // so the live request is used in IDLE and the latched copy elsewhere.
    assign acc_rd    = (state_reg == ST_IDLE) ? bus.memRead : op_rd_reg;
    assign acc_adr   = (state_reg == ST_IDLE) ? bus.adr     : adr_reg;
    assign acc_wdata = (state_reg == ST_IDLE) ? bus.wdata   : wdata_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        err_set    = 1'b0;
        enter_resp = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.memRead ^ bus.memWrite) begin
                    accept   = 1'b1;
                    cnt_next = CNT_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end else if (bus.memRead && bus.memWrite) begin
                    err_set = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            op_rd_reg <= 1'b0;
            adr_reg   <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                op_rd_reg <= bus.memRead;
                adr_reg   <= bus.adr;
                wdata_reg <= bus.wdata;
            end
            if (err_set) begin
                err_reg <= 1'b1;
            end
            if (enter_resp && acc_rd) begin
                rdata_reg <= ram[acc_adr];
            end
        end
    end

    // Kept separate from the reset block so the array maps onto block RAM;
    // reset still suppresses a write that coincides with the edge into RESP.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && !acc_rd) begin
            ram[acc_adr] <= acc_wdata;
        end
    end

    assign bus.rdata = rdata_reg;
    assign bus.err   = err_reg;
    // Masked by rst so a reset landing in RESP never shows a completion.
    assign bus.ready = (state_reg == ST_RESP) && !rst;

`ifdef MEM_RESP_PERF_EN
    logic [15:0] rd_count_reg;
    logic [15:0] wr_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_reg <= 16'd0;
            wr_count_reg <= 16'd0;
        end else if (state_reg == ST_RESP) begin
            if (op_rd_reg && rd_count_reg != 16'hFFFF) begin
                rd_count_reg <= rd_count_reg + 16'd1;
            end
            if (!op_rd_reg && wr_count_reg != 16'hFFFF) begin
                wr_count_reg <= wr_count_reg + 16'd1;
            end
        end
    end

    assign bus.rd_count = rd_count_reg;
    assign bus.wr_count = wr_count_reg;
`else
    assign bus.rd_count = 16'd0;
    assign bus.wr_count = 16'd0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Three responders (WAIT_STATES 1, 0, 3) driven by directed transactions.
// A cycle-count model (request accepted at T completes at T+1+WS, memory as
// an array) is checked against every DUT on each negative clock edge, and the
// directed sequence adds literal expectations taken from hand calculation.
module tb_mem_responder;
    localparam int N = 3;
`ifdef MEM_RESP_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v [N];
    logic       mr    [N];
    logic       mw    [N];
    logic [4:0] ad    [N];
    logic [7:0] wd    [N];
    logic       rdy   [N];
    logic       er    [N];
    logic [7:0] rd    [N];
    logic [15:0] rc   [N];
    logic [15:0] wc   [N];

    int cyc  = 0;
    int nchk = 0;
    int nerr = 0;

    function automatic int ws_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : 3;
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        mem_responder_if #(.ADDR_W(5), .DATA_W(8)) bus ();
        assign bus.memRead  = mr[gi];
        assign bus.memWrite = mw[gi];
        assign bus.adr      = ad[gi];
        assign bus.wdata    = wd[gi];
        assign rdy[gi]      = bus.ready;
        assign er[gi]       = bus.err;
        assign rd[gi]       = bus.rdata;
        assign rc[gi]       = bus.rd_count;
        assign wc[gi]       = bus.wr_count;
        mem_responder #(
            .ADDR_W(5), .DATA_W(8),
            .WAIT_STATES((gi == 0) ? 1 : (gi == 1) ? 0 : 3)
        ) u_dut (
            .clk (clk),
            .rst (rst_v[gi]),
            .bus (bus.slave)
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_busy    [N];
    int         m_done    [N];
    bit         m_idle    [N];
    bit         m_op_rd   [N];
    logic [4:0] m_adr     [N];
    logic [7:0] m_wd      [N];
    logic [7:0] m_mem     [N][32];
    bit         m_known   [N][32];
    bit         m_ready   [N];
    bit         m_err     [N];
    logic [7:0] m_rdata   [N];
    bit         m_rdk     [N];
    int         m_rc      [N];
    int         m_wc      [N];

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int i = 0; i < N; i++) begin
                if (rst_v[i]) begin
                    m_busy[i] = 0; m_idle[i] = 1; m_ready[i] = 0; m_err[i] = 0;
                    m_rdata[i] = 8'h00; m_rdk[i] = 1; m_rc[i] = 0; m_wc[i] = 0;
                end else begin
                    bit cur_idle;
                    if (m_idle[i]) begin
                        if (mr[i] ^ mw[i]) begin
                            m_busy[i]  = 1;
                            m_done[i]  = cyc + ws_of(i);
                            m_op_rd[i] = mr[i];
                            m_adr[i]   = ad[i];
                            m_wd[i]    = wd[i];
                        end else if (mr[i] && mw[i]) begin
                            m_err[i] = 1;
                        end
                    end
                    m_ready[i] = m_busy[i] && (cyc == m_done[i]);
                    if (m_ready[i]) begin
                        if (m_op_rd[i]) begin
                            m_rdata[i] = m_mem[i][m_adr[i]];
                            m_rdk[i]   = m_known[i][m_adr[i]];
                            if (m_rc[i] < 65535) m_rc[i]++;
                        end else begin
                            m_mem[i][m_adr[i]]   = m_wd[i];
                            m_known[i][m_adr[i]] = 1;
                            if (m_wc[i] < 65535) m_wc[i]++;
                        end
                    end
                    cur_idle = !m_busy[i];
                    if (m_ready[i]) m_busy[i] = 0;
                    m_idle[i] = cur_idle;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("i%0d_ready", i), 32'(rdy[i]), 32'(m_ready[i]));
                    chk($sformatf("i%0d_err", i), 32'(er[i]), 32'(m_err[i]));
                    if (m_rdk[i]) chk($sformatf("i%0d_rdata", i), 32'(rd[i]), 32'(m_rdata[i]));
                    chk($sformatf("i%0d_rd_count", i), 32'(rc[i]), PERF ? 32'(m_rc[i]) : 32'd0);
                    chk($sformatf("i%0d_wr_count", i), 32'(wc[i]), PERF ? 32'(m_wc[i]) : 32'd0);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic req(input int i, input bit r, input bit w, input logic [4:0] a,
                       input logic [7:0] d, output int lat);
        int t0;
        bit got;
        @(posedge clk); #1;
        mr[i] = r; mw[i] = w; ad[i] = a; wd[i] = d;
        t0 = cyc; got = 0; lat = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #1;
            if (rdy[i]) begin
                got = 1;
                lat = cyc - t0;
            end
        end
        mr[i] = 0; mw[i] = 0;
        if (!got) chk($sformatf("i%0d_ready_timeout", i), 32'd0, 32'd1);
        $display("txn inst%0d %s adr=%0d wdata=%02h latency=%0d rdata=%02h",
                 i, r ? "RD" : "WR", a, d, lat, rd[i]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int lat;
        for (int i = 0; i < N; i++) begin
            rst_v[i] = 1; mr[i] = 0; mw[i] = 0; ad[i] = '0; wd[i] = '0;
        end
        idle(2);
        chk("reset_rdata", 32'(rd[0]), 32'h00);
        chk("reset_err", 32'(er[0]), 32'd0);
        for (int i = 0; i < N; i++) rst_v[i] = 0;
        idle(1);

        // WAIT_STATES=1: write then read
        req(0, 0, 1, 5'd3, 8'hA5, lat);
        chk("ws1_wr_latency", 32'(lat), 32'd2);
        idle(1);
        req(0, 1, 0, 5'd3, 8'h00, lat);
        chk("ws1_rd_latency", 32'(lat), 32'd2);
        chk("ws1_rdata", 32'(rd[0]), 32'hA5);

        // WAIT_STATES=0 back-to-back
        req(1, 0, 1, 5'd0, 8'h3C, lat);
        chk("ws0_wr_latency", 32'(lat), 32'd1);
        req(1, 1, 0, 5'd0, 8'h00, lat);
        chk("ws0_rd_latency", 32'(lat), 32'd1);
        chk("ws0_rdata", 32'(rd[1]), 32'h3C);

        // Illegal simultaneous request on inst0
        @(posedge clk); #1;
        mr[0] = 1; mw[0] = 1; ad[0] = 5'd3; wd[0] = 8'h00;
        @(posedge clk); #1;
        mr[0] = 0; mw[0] = 0;
        chk("illegal_err_set", 32'(er[0]), 32'd1);
        chk("illegal_no_ready", 32'(rdy[0]), 32'd0);
        idle(3);
        req(0, 1, 0, 5'd3, 8'h00, lat);
        chk("illegal_ram_unchanged", 32'(rd[0]), 32'hA5);

        // rdata hold across a write
        req(0, 0, 1, 5'd1, 8'h11, lat);
        req(0, 1, 0, 5'd1, 8'h00, lat);
        chk("hold_read", 32'(rd[0]), 32'h11);
        req(0, 0, 1, 5'd2, 8'h22, lat);
        chk("hold_after_write", 32'(rd[0]), 32'h11);
        chk("err_sticky", 32'(er[0]), 32'd1);

        // Reset in the second WAIT cycle, WAIT_STATES=3
        req(2, 0, 1, 5'd7, 8'h77, lat);
        chk("ws3_wr_latency", 32'(lat), 32'd4);
        @(posedge clk); #1;
        mw[2] = 1; ad[2] = 5'd7; wd[2] = 8'hFF;
        idle(2);
        rst_v[2] = 1; mw[2] = 0;
        idle(1);
        rst_v[2] = 0;
        for (int k = 0; k < 6; k++) begin
            chk("rst_mid_no_ready", 32'(rdy[2]), 32'd0);
            idle(1);
        end
        req(2, 1, 0, 5'd7, 8'h00, lat);
        chk("rst_mid_old_value", 32'(rd[2]), 32'h77);

        // Counters: 2 writes + 3 reads after a fresh reset of inst1
        @(posedge clk); #1;
        rst_v[1] = 1;
        idle(1);
        rst_v[1] = 0;
        req(1, 0, 1, 5'd4, 8'h44, lat);
        req(1, 1, 0, 5'd0, 8'h00, lat);
        req(1, 0, 1, 5'd5, 8'h55, lat);
        req(1, 1, 0, 5'd4, 8'h00, lat);
        req(1, 1, 0, 5'd5, 8'h00, lat);
        chk("perf_rdata", 32'(rd[1]), 32'h55);
        idle(1);
        chk("perf_rd_count", 32'(rc[1]), PERF ? 32'd3 : 32'd0);
        chk("perf_wr_count", 32'(wc[1]), PERF ? 32'd2 : 32'd0);

        // err cleared only by reset
        rst_v[0] = 1;
        idle(1);
        rst_v[0] = 0;
        idle(1);
        chk("err_cleared_by_rst", 32'(er[0]), 32'd0);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle accumulator CPU's memory port. Serves the `memRead`/`memWrite` requests issued by the CPU controller against an internal word-addressed RAM, inserting a configurable number of wait states and signalling completion with a one-cycle `ready` pulse. It sits between the datapath's address/data mux (`IorD` output) and storage, and replaces the ideal zero-latency memory model so the controller can be run against realistic stalls.

## Interface
- `ADDR_W`, 5, address width; RAM depth is 2^ADDR_W words.
- `DATA_W`, 8, word width; matches the 8-bit instruction/data word.
- `WAIT_STATES`, 1, extra cycles between request acceptance and `ready`; legal range 0..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `memRead`  in  1  read request.
- `memWrite`  in  1  write request.
- `adr`  in  ADDR_W  word address.
- `wdata`  in  DATA_W  write data.
- `rdata`  out  DATA_W  read data, registered.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky flag: illegal simultaneous read and write.
- `rd_count`  out  16  completed reads (see Configuration).
- `wr_count`  out  16  completed writes (see Configuration).

## Operation
- Registered FSM with 3 states: IDLE, WAIT, RESP. Wait counter is 4 bits.
- **IDLE:** samples requests every cycle.
  - Exactly one of `memRead`/`memWrite` high: latch op, `adr`, and `wdata`; load counter = WAIT_STATES−1.
    - WAIT_STATES = 0: go to RESP.
    - Otherwise: go to WAIT.
  - Both high: set `err`, perform no access, stay IDLE.
  - Neither high: stay IDLE.
- **WAIT:**
  - Counter ≠ 0: decrement and stay in WAIT.
  - Counter = 0: go to RESP.
  - Request inputs are ignored in WAIT; the latched copy is used.
- **Transition edge into RESP:**
  - Write: RAM[latched adr] ← latched wdata.
  - Read: `rdata` ← RAM[latched adr].
- **RESP:** `ready` = 1 for exactly this cycle, then go to IDLE.
- `rdata` holds its value until the next read completes. Writes and idle cycles do not change it.
- The requester must hold its request until it sees `ready`, and must deassert it in the cycle after `ready`. A request still high in the cycle after `ready` is accepted as a new request.
- Address space is the full 2^ADDR_W; wrap-around is not possible.
- `err` is cleared only by `rst`.

## Timing
- Reset values: state = IDLE, counter 0, `ready` 0, `rdata` 0, `err` 0, `rd_count` 0, `wr_count` 0.
- RAM contents are not cleared by reset.
- Latency: a request first seen in IDLE at cycle T gives `ready` high in cycle T+1+WAIT_STATES.
- Written data is visible to any read accepted in the cycle after `ready` or later.
- Back-to-back throughput: one access per 2+WAIT_STATES cycles (the IDLE accept cycle, the wait cycles, and the RESP cycle).
- Reset asserted in WAIT or RESP:
  - State returns to IDLE on that edge.
  - A pending write is not committed if reset coincides with the edge into RESP; reset has priority.
  - No `ready` pulse is produced.
- `err` is set on the edge after the illegal cycle.

## Configuration
- Macro: `MEM_RESP_PERF_EN`.
- **Defined:**
  - `rd_count` increments by 1 on each RESP cycle that completes a read.
  - `wr_count` increments by 1 on each RESP cycle that completes a write.
  - Both counters saturate at 16'hFFFF.
  - Both counters are cleared by `rst`.
- **Undefined:** `rd_count` and `wr_count` are tied to 0 and no counter flops are built. Ports remain present.

## Test plan
- **Write then read, WAIT_STATES=1:** write 8'hA5 to adr 5'd3 at T → `ready` at T+2. Read adr 3 at T+3 → `ready` at T+5 with `rdata`=8'hA5.
- **WAIT_STATES=0 back-to-back:** write 8'h3C to adr 0, then read adr 0 → each `ready` arrives 1 cycle after its request; `rdata`=8'h3C.
- **Illegal request:** `memRead`=`memWrite`=1 for 1 cycle → `err`=1 next cycle; no `ready`; RAM unchanged. `err` stays 1 until `rst`.
- **Reset mid-access, WAIT_STATES=3:** write 8'hFF to adr 7; assert `rst` in the 2nd WAIT cycle → no `ready`. A later read of adr 7 returns the old value.
- **`rdata` hold:** read adr 1 (8'h11), then write adr 2 → `rdata` stays 8'h11 through the write's `ready`.
- **`MEM_RESP_PERF_EN` defined:** 3 reads + 2 writes → `rd_count`=3, `wr_count`=2. With the macro undefined, both read 0.
